// File: rtl/conv_line_buffer.sv
// conv_line_buffer: buffers a raster pixel stream into four row slots and
// presents zero-padded 3-row windows to the convolution stage.
module conv_line_buffer #(
    parameter int D          = 4,
    parameter int H          = 12,
    parameter int W          = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rstn_i,
    input  logic [DATA_WIDTH*D-1:0]        pix_i,
    input  logic                           pix_valid_i,
    output logic                           pix_ready_o,
    output logic [DATA_WIDTH*D*(W+2)-1:0]  image0,
    output logic [DATA_WIDTH*D*(W+2)-1:0]  image1,
    output logic [DATA_WIDTH*D*(W+2)-1:0]  image2,
    output logic                           image_start,
    input  logic                           win_done_i,
    output logic [$clog2(H)-1:0]           win_row_o,
    output logic                           frame_done_o
);

    localparam int PW = DATA_WIDTH * D;
    localparam int SW = DATA_WIDTH * (W + 2);
    localparam int RB = PW * (W + 2);
    localparam int CW = $clog2(H + 3);
    localparam int RW = $clog2(H);
    localparam int XW = $clog2(W);

    localparam logic [CW-1:0] H_C   = CW'(H);
    localparam logic [CW-1:0] HM1_C = CW'(H - 1);
    localparam logic [CW-1:0] TWO_C = CW'(2);
    localparam logic [XW-1:0] WM1_C = XW'(W - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   col_q, col_d;
    logic [CW-1:0]   wr_row_q, wr_row_d;
    logic [RW-1:0]   win_row_q, win_row_d;
    logic            ready_q, ready_d;
    logic            start_q, start_d;
    logic            fdone_q, fdone_d;
    logic [RB-1:0]   img0_q, img1_q, img2_q;

    logic            acc;
    logic            avail;
    logic            load;
    logic [1:0]      wr_slot;
    logic [CW-1:0]   win_ext;
    logic [CW-1:0]   win_ext_d;
    logic [1:0]      slot_m1, slot_0, slot_p1;
    logic [RB-1:0]   row_m1, row_0, row_p1;

    logic [W*PW-1:0] mem_q [4];
    logic [W*PW-1:0] view  [4];

    assign acc     = pix_valid_i && ready_q;
    assign wr_slot = wr_row_q[1:0];
    assign win_ext = CW'(win_row_q);
    assign slot_m1 = 2'(win_ext - CW'(1));
    assign slot_0  = 2'(win_ext);
    assign slot_p1 = 2'(win_ext + CW'(1));

    // Row slot storage; slots need no reset since they are always written before use
    always_ff @(posedge clk) begin
        if (acc) begin
            mem_q[wr_slot][PW*col_q +: PW] <= pix_i;
        end
    end

    // Slot view with the beat being accepted forwarded, so a window can latch on that edge
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            view[s] = mem_q[s];
            if (acc && wr_slot == 2'(s)) begin
                view[s][PW*col_q +: PW] = pix_i;
            end
        end
    end

    function automatic logic [RB-1:0] pad_row(input logic [W*PW-1:0] row);
        logic [RB-1:0] r;
        r = '0;
        for (int ch = 0; ch < D; ch++) begin
            for (int c = 0; c < W; c++) begin
                r[SW*ch + DATA_WIDTH*(c+1) +: DATA_WIDTH] =
                    row[PW*c + DATA_WIDTH*ch +: DATA_WIDTH];
            end
        end
        return r;
    endfunction

    // Padded window rows; rows outside the image read as zero
    always_comb begin
        row_m1 = '0;
        row_0  = pad_row(view[slot_0]);
        row_p1 = '0;
        if (win_ext != '0) begin
            row_m1 = pad_row(view[slot_m1]);
        end
        if (win_ext != HM1_C) begin
            row_p1 = pad_row(view[slot_p1]);
        end
    end

    // Counter advance, window FSM and registered ready
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        wr_row_d  = wr_row_q;
        win_row_d = win_row_q;
        start_d   = 1'b0;
        fdone_d   = 1'b0;
        load      = 1'b0;
        avail     = 1'b0;

        if (acc) begin
            if (col_q == WM1_C) begin
                col_d    = '0;
                wr_row_d = wr_row_q + CW'(1);
            end else begin
                col_d = col_q + XW'(1);
            end
        end

        avail = (wr_row_d >= win_ext + TWO_C) ||
                (wr_row_d == H_C && win_ext == HM1_C);

        unique case (state_q)
            S_IDLE: begin
                if (avail) begin
                    load    = 1'b1;
                    start_d = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (win_done_i) begin
                    state_d = S_IDLE;
                    if (win_ext == HM1_C) begin
                        win_row_d = '0;
                        wr_row_d  = '0;
                        col_d     = '0;
                        fdone_d   = 1'b1;
                    end else begin
                        win_row_d = win_row_q + RW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        win_ext_d = CW'(win_row_d);
        ready_d   = (wr_row_d < H_C) && (wr_row_d <= win_ext_d + TWO_C);
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            wr_row_q  <= '0;
            win_row_q <= '0;
            ready_q   <= 1'b1;
            start_q   <= 1'b0;
            fdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            wr_row_q  <= wr_row_d;
            win_row_q <= win_row_d;
            ready_q   <= ready_d;
            start_q   <= start_d;
            fdone_q   <= fdone_d;
        end
    end

    // Window registers, held stable while the consumer works on them
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            img0_q <= '0;
            img1_q <= '0;
            img2_q <= '0;
        end else if (load) begin
            img0_q <= row_m1;
            img1_q <= row_0;
            img2_q <= row_p1;
        end
    end

    assign pix_ready_o  = ready_q;
    assign image0       = img0_q;
    assign image1       = img1_q;
    assign image2       = img2_q;
    assign image_start  = start_q;
    assign win_row_o    = win_row_q;
    assign frame_done_o = fdone_q;

endmodule

// File: doc/conv_line_buffer.md
Name: conv_line_buffer

Overview:
Upstream feeder for the convolution top stage. It accepts a raster-order pixel stream, with all D channels of one pixel per beat, and buffers the rows. For each output row r it presents the zero-padded 3-row window (rows r-1, r, r+1) on image0/image1/image2 and pulses image_start. The consumer acknowledges each window with win_done_i, normally wired from the stage's add-done output.

Parameters:
D, 4, input channels per pixel
H, 12, image height (rows); H >= 2
W, 12, image width (columns); W >= 2
DATA_WIDTH, 8, bits per channel sample

Ports:
clk  in  1  clock, rising edge
rstn_i  in  1  reset; one clock, asynchronous, active-low
pix_i  in  DATA_WIDTH*D  one pixel; channel i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
pix_valid_i  in  1  pix_i valid
pix_ready_o  out  1  buffer can accept; beat transfers when valid && ready
image0  out  DATA_WIDTH*D*(W+2)  padded row r-1
image1  out  DATA_WIDTH*D*(W+2)  padded row r
image2  out  DATA_WIDTH*D*(W+2)  padded row r+1
image_start  out  1  one-cycle pulse: new window valid on image0..2
win_done_i  in  1  consumer finished current window (pulse)
win_row_o  out  clog2(H)  row index r of current/pending window
frame_done_o  out  1  one-cycle pulse after last window acknowledged

Behaviour:
- Window packing: channel i occupies [DATA_WIDTH*(W+2)*(i+1)-1 : DATA_WIDTH*(W+2)*i]. Within a channel, column c (0..W+1) occupies [DATA_WIDTH*(c+1)-1 : DATA_WIDTH*c]. Columns 0 and W+1 are always 0; column c holds input pixel c-1.
- Row r = 0: image0 is all zero. Row r = H-1: image2 is all zero.
- Storage: 4 row slots of D*W*DATA_WIDTH bits. Input row n is written to slot n mod 4.
- Counters:
  - col_cnt 0..W-1 advances per accepted beat; it wraps to 0 and increments wr_row at column W-1.
  - wr_row 0..H; H means the frame is fully received.
  - win_row 0..H-1.
- pix_ready_o = (wr_row < H) && (wr_row <= win_row + 2), both terms registered. This guarantees a slot still needed by the displayed window is never overwritten.
- FSM states:
  - IDLE: the window for win_row is not yet issued. The window is available when wr_row >= win_row + 2, or when wr_row == H and win_row == H-1. On the clock edge where it is available, latch image0..2 from slots and pulse image_start for exactly one cycle; go to BUSY.
  - BUSY: image0..2 are held stable. On win_done_i:
    - if win_row == H-1: win_row <= 0, wr_row <= 0, col_cnt <= 0, pulse frame_done_o, go to IDLE.
    - else: win_row <= win_row + 1, go to IDLE.
- Latency: image_start is asserted in the cycle after the clock edge that accepts the last pixel of the row that completes the window. Worst case is the beat that increments wr_row.
- Ignoring rules:
  - win_done_i in IDLE is ignored.
  - pix_valid_i while pix_ready_o = 0 is ignored, and no beat is consumed.
- Simultaneous events:
  - A pixel accept and win_done_i in the same cycle are both applied; pix_ready_o re-evaluates from the updated counters next cycle.
  - In the frame-end case, a pixel offered in that cycle is not accepted, since wr_row == H.
- Frames do not overlap: the next frame's pixels are held off until frame_done_o.
- Reset values: pix_ready_o = 1, image0/1/2 = 0, image_start = 0, win_row_o = 0, frame_done_o = 0, state = IDLE, all counters 0. Slot contents need not be cleared.
- Reset asserted mid-frame aborts the frame immediately, asynchronously, to the reset values.
- Arithmetic: pure data movement with no arithmetic on samples. Counter compares are unsigned at width clog2(H+3).

Test Plan:
- Params D=1, H=4, W=4. Stream pixel(r,c) = 16*r + c + 1 with valid held high, and ack each window 5 cycles after image_start.
  - First image_start occurs 1 cycle after beat 8 is accepted.
  - image0 = 0.
  - image1 = {00,04,03,02,01,00}.
  - image2 = {00,14,13,12,11,00}.
- Same stream, window r = 3:
  - image0 holds row 2 (21..24).
  - image1 holds row 3 (31..34).
  - image2 = 0.
  - frame_done_o pulses 1 cycle after win_done_i.
  - win_row_o returns to 0.
- Backpressure: never assert win_done_i.
  - pix_ready_o drops after row 2 completes (12 beats accepted).
  - Further valid beats are not consumed.
  - image1 stays at row 0 values.
- Simultaneous: assert win_done_i in the same cycle that a row-2 beat is accepted.
  - Both take effect.
  - The window for r = 1 issues on the next edge once row 2 is complete.
  - No beat is lost or duplicated (compare against a scoreboard).
- D=4 packing: channel i value = 0x10*i + c.
  - Channel slices land at offsets DATA_WIDTH*(W+2)*i.
  - Padding columns are 0 in every channel.
- Reset mid-frame: drop rstn_i while in BUSY at win_row = 2.
  - All outputs go to reset values without waiting for a clock edge.
  - A fresh frame afterwards reproduces the first scenario exactly.
